// File: rtl/bitmap_compressor_if.sv
// bitmap_compressor_if: dense-element input and compressed-tile output bundle for bitmap_compressor.
// Optional: COMPRESS_FLUSH_EN adds in_flush (end the current tile early).
// Signals:
//   in_valid/in_ready/in_data    dense element stream, one element per accept, row-major
//   in_flush                     (COMPRESS_FLUSH_EN only) close the tile after this cycle
//   out_valid/out_ready          compressed tile handshake
//   bit_map                      occupancy, bit r*COL_SIZE+c set when element (r,c) is nonzero
//   nonzero_ele                  packed nonzero slots, slot k at [k*DATA_TYPE +: DATA_TYPE]
//   nnz_count                    number of valid slots
//   overflow                     tile held more nonzeros than BUFF_SIZE
// Modports: slave = the compressor, master = the producer/consumer driving it.
interface bitmap_compressor_if #(
    parameter int ROW_SIZE       = 4,
    parameter int COL_SIZE       = 8,
    parameter int BUFF_SIZE      = 32,
    parameter int DATA_TYPE      = 32,
    parameter int LOG2_BUFF_SIZE = 5
);
    logic                            in_valid;
    logic                            in_ready;
    logic [DATA_TYPE-1:0]            in_data;
`ifdef COMPRESS_FLUSH_EN
    logic                            in_flush;
`endif
    logic                            out_valid;
    logic                            out_ready;
    logic [ROW_SIZE*COL_SIZE-1:0]    bit_map;
    logic [BUFF_SIZE*DATA_TYPE-1:0]  nonzero_ele;
    logic [LOG2_BUFF_SIZE:0]         nnz_count;
    logic                            overflow;

    modport slave (
        input  in_valid, in_data, out_ready,
`ifdef COMPRESS_FLUSH_EN
        input  in_flush,
`endif
        output in_ready, out_valid, bit_map, nonzero_ele, nnz_count, overflow
    );

    modport master (
        output in_valid, in_data, out_ready,
`ifdef COMPRESS_FLUSH_EN
        output in_flush,
`endif
        input  in_ready, out_valid, bit_map, nonzero_ele, nnz_count, overflow
    );
endinterface

// File: rtl/bitmap_compressor.sv
// bitmap_compressor: encodes a dense ROW_SIZE x COL_SIZE tile into an occupancy bitmap plus packed nonzero values.
// Optional: COMPRESS_FLUSH_EN enables bus.in_flush to close a tile before all elements arrive.
// Ports:
//   clk  single clock, all logic on posedge
//   rst  asynchronous active-low reset, discards any partial tile
//   bus  bitmap_compressor_if.slave: element input handshake, compressed tile output handshake
// Operation: COLLECT accepts elements (in_ready=1) until the last index (or a flush),
// then HOLD presents the tile (out_valid=1) until out_ready, after which everything clears.
module bitmap_compressor #(
    parameter int ROW_SIZE       = 4,
    parameter int COL_SIZE       = 8,
    parameter int BUFF_SIZE      = 32,
    parameter int DATA_TYPE      = 32,
    parameter int LOG2_ROW_SIZE  = 2,
    parameter int LOG2_COL_SIZE  = 3,
    parameter int LOG2_BUFF_SIZE = 5
) (
    input logic                clk,
    input logic                rst,
    bitmap_compressor_if.slave bus
);
    localparam int NUM   = ROW_SIZE * COL_SIZE;
    localparam int IDX_W = LOG2_ROW_SIZE + LOG2_COL_SIZE;
    localparam logic [IDX_W-1:0]        LAST_IDX  = IDX_W'(NUM - 1);
    localparam logic [LOG2_BUFF_SIZE:0] BUFF_FULL = (LOG2_BUFF_SIZE + 1)'(BUFF_SIZE);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [NUM-1:0]              map_q, map_d;
    logic [DATA_TYPE-1:0]        ele_q [BUFF_SIZE];
    logic [DATA_TYPE-1:0]        ele_d [BUFF_SIZE];
    logic [LOG2_BUFF_SIZE:0]     nnz_q, nnz_d;
    logic                        ovf_q, ovf_d;
    logic                        accept;
    logic                        flush;

`ifdef COMPRESS_FLUSH_EN
    assign flush = bus.in_flush;
`else
    assign flush = 1'b0;
`endif

    assign accept = (state_q == COLLECT) && bus.in_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= COLLECT;
            idx_q   <= '0;
            map_q   <= '0;
            ele_q   <= '{default: '0};
            nnz_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            map_q   <= map_d;
            ele_q   <= ele_d;
            nnz_q   <= nnz_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        map_d   = map_q;
        ele_d   = ele_q;
        nnz_d   = nnz_q;
        ovf_d   = ovf_q;
        if (state_q == COLLECT) begin
            if (accept) begin
                idx_d = idx_q + 1'b1;
                if (bus.in_data != '0) begin
                    map_d[idx_q] = 1'b1;
                    // Slots fill in arrival order; once full, further nonzeros only mark the bitmap.
                    if (nnz_q < BUFF_FULL) begin
                        ele_d[nnz_q[LOG2_BUFF_SIZE-1:0]] = bus.in_data;
                        nnz_d = nnz_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            // A flush coinciding with an element closes the tile after encoding that element.
            if ((accept && idx_q == LAST_IDX) || flush)
                state_d = HOLD;
        end else if (bus.out_ready) begin
            state_d = COLLECT;
            idx_d   = '0;
            map_d   = '0;
            ele_d   = '{default: '0};
            nnz_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    assign bus.in_ready  = (state_q == COLLECT);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.bit_map   = map_q;
    assign bus.nnz_count = nnz_q;
    assign bus.overflow  = ovf_q;

    for (genvar k = 0; k < BUFF_SIZE; k++) begin : g_pack
        assign bus.nonzero_ele[k*DATA_TYPE +: DATA_TYPE] = ele_q[k];
    end

`ifndef SYNTHESIS
    a_count_bound: assert property (@(posedge clk) disable iff (!rst) nnz_q <= BUFF_FULL);
    a_ovf_full:    assert property (@(posedge clk) disable iff (!rst) ovf_q |-> nnz_q == BUFF_FULL);
    a_hold_stable: assert property (@(posedge clk) disable iff (!rst)
                       (state_q == HOLD && !bus.out_ready) |=>
                       (state_q == HOLD && $stable(map_q) && $stable(nnz_q) && $stable(ovf_q)));
`endif
endmodule

// File: tb/tb_bitmap_compressor.sv
// tb_bitmap_compressor: randomized and directed checks of bitmap_compressor against a queue-based tile model.
// Two instances share the stimulus: BUFF_SIZE=32 (ia/dut_a) and BUFF_SIZE=16 (ib/dut_b, exercises overflow).
module tb_bitmap_compressor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bitmap_compressor_if ia ();
    bitmap_compressor_if #(.BUFF_SIZE(16), .LOG2_BUFF_SIZE(4)) ib ();

    assign ib.in_valid  = ia.in_valid;
    assign ib.in_data   = ia.in_data;
    assign ib.out_ready = ia.out_ready;
`ifdef COMPRESS_FLUSH_EN
    assign ib.in_flush  = ia.in_flush;
`endif

    bitmap_compressor dut_a (.clk(clk), .rst(rst), .bus(ia));
    bitmap_compressor #(.BUFF_SIZE(16), .LOG2_BUFF_SIZE(4)) dut_b (.clk(clk), .rst(rst), .bus(ib));

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] tile [32];
    logic [31:0] e_map;
    logic [31:0] e_q [$];
    int          e_nnz_a, e_nnz_b;
    logic        e_ovf_a, e_ovf_b;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Expected tile: every nonzero lands in the bitmap; the buffer keeps the first B of them in order.
    task automatic model();
        e_q.delete();
        e_map = '0;
        for (int i = 0; i < 32; i++)
            if (tile[i] != 0) begin
                e_map[i] = 1'b1;
                e_q.push_back(tile[i]);
            end
        e_nnz_a = (e_q.size() < 32) ? e_q.size() : 32;
        e_nnz_b = (e_q.size() < 16) ? e_q.size() : 16;
        e_ovf_a = e_q.size() > 32;
        e_ovf_b = e_q.size() > 16;
    endtask

    task automatic check_tile(input string tag);
        check({tag, ".a_vld"}, ia.out_valid, 1);
        check({tag, ".a_rdy"}, ia.in_ready, 0);
        check({tag, ".b_vld"}, ib.out_valid, 1);
        check({tag, ".b_rdy"}, ib.in_ready, 0);
        check({tag, ".a_map"}, ia.bit_map, e_map);
        check({tag, ".b_map"}, ib.bit_map, e_map);
        check({tag, ".a_nnz"}, ia.nnz_count, e_nnz_a);
        check({tag, ".b_nnz"}, ib.nnz_count, e_nnz_b);
        check({tag, ".a_ovf"}, ia.overflow, e_ovf_a);
        check({tag, ".b_ovf"}, ib.overflow, e_ovf_b);
        for (int k = 0; k < 32; k++)
            check($sformatf("%s.a_slot%0d", tag, k), ia.nonzero_ele[k*32 +: 32], (k < e_nnz_a) ? e_q[k] : 32'h0);
        for (int k = 0; k < 16; k++)
            check($sformatf("%s.b_slot%0d", tag, k), ib.nonzero_ele[k*32 +: 32], (k < e_nnz_b) ? e_q[k] : 32'h0);
    endtask

    task automatic check_clear(input string tag);
        check({tag, ".a_vld"}, ia.out_valid, 0);
        check({tag, ".a_rdy"}, ia.in_ready, 1);
        check({tag, ".a_map"}, ia.bit_map, 0);
        check({tag, ".a_nnz"}, ia.nnz_count, 0);
        check({tag, ".a_ovf"}, ia.overflow, 0);
        check({tag, ".a_slot0"}, ia.nonzero_ele[31:0], 0);
        check({tag, ".b_vld"}, ib.out_valid, 0);
        check({tag, ".b_map"}, ib.bit_map, 0);
        check({tag, ".b_nnz"}, ib.nnz_count, 0);
        check({tag, ".b_ovf"}, ib.overflow, 0);
    endtask

    // mode 0: back-to-back, 1: bubble before every element after the first, 2: random bubbles and out_ready noise
    task automatic send_tile(input int mode);
        for (int i = 0; i < 32; i++) begin
            if ((mode == 1 && i > 0) || (mode == 2 && $urandom_range(3) == 0)) begin
                ia.in_valid = 1'b0;
                ia.in_data  = $urandom | 32'h1;
                @(posedge clk); #1;
            end
            ia.in_valid  = 1'b1;
            ia.in_data   = tile[i];
            ia.out_ready = (mode == 2) ? 1'($urandom_range(1)) : 1'b0;
            if (i == 0)  check("first.rdy", ia.in_ready, 1);
            if (i == 31) check("pre_last.vld", ia.out_valid, 0);
            @(posedge clk); #1;
        end
        ia.in_valid  = 1'b0;
        ia.out_ready = 1'b0;
    endtask

    // Hold the tile for n cycles with junk on the input side, then release it.
    task automatic hold_release(input int n, input string tag);
        ia.in_valid = 1'b1;
        ia.in_data  = 32'hDEAD_BEEF;
`ifdef COMPRESS_FLUSH_EN
        ia.in_flush = 1'b1;
`endif
        repeat (n) begin
            @(posedge clk); #1;
            check_tile({tag, ".hold"});
        end
        ia.in_valid  = 1'b0;
`ifdef COMPRESS_FLUSH_EN
        ia.in_flush  = 1'b0;
`endif
        ia.out_ready = 1'b1;
        @(posedge clk); #1;
        ia.out_ready = 1'b0;
        check_clear({tag, ".rel"});
    endtask

    function automatic logic [31:0] rnd_nz();
        logic [31:0] v;
        case ($urandom_range(3))
            0:       v = 32'h8000_0000;
            1:       v = 32'h1;
            default: v = $urandom;
        endcase
        return (v == 0) ? 32'h1 : v;
    endfunction

    initial begin
        logic [31:0] val;
        int p;
        ia.in_valid  = 1'b0;
        ia.in_data   = '0;
        ia.out_ready = 1'b0;
`ifdef COMPRESS_FLUSH_EN
        ia.in_flush  = 1'b0;
`endif
        #1 rst = 1'b0;
        #3;
        check_clear("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Directed tile: nonzeros 1..11 at indices 2,3,5,6,18,21,23,26,27,29,31
        for (int i = 0; i < 32; i++) tile[i] = '0;
        val = 1;
        foreach (tile[i])
            if (i inside {2, 3, 5, 6, 18, 21, 23, 26, 27, 29, 31}) begin
                tile[i] = val;
                val++;
            end
        model();
        send_tile(0);
        check("dir.map", ia.bit_map, 32'hACA4_006C);
        check("dir.nnz", ia.nnz_count, 11);
        check("dir.ovf", ia.overflow, 0);
        for (int k = 0; k < 11; k++) check($sformatf("dir.slot%0d", k), ia.nonzero_ele[k*32 +: 32], k + 1);
        check("dir.slot11", ia.nonzero_ele[11*32 +: 32], 0);
        check_tile("dir");
        hold_release(0, "dir");

        // Same tile with alternating bubbles and a 5-cycle stall
        send_tile(1);
        check_tile("bub");
        hold_release(5, "bub");

        // Fully dense tile: the 16-slot instance overflows
        for (int i = 0; i < 32; i++) tile[i] = 32'hFFFF_0001;
        model();
        send_tile(0);
        check("dense.a_map", ia.bit_map, 32'hFFFF_FFFF);
        check("dense.a_nnz", ia.nnz_count, 32);
        check("dense.a_ovf", ia.overflow, 0);
        check("dense.b_nnz", ib.nnz_count, 16);
        check("dense.b_ovf", ib.overflow, 1);
        check_tile("dense");
        hold_release(1, "dense");

        // All-zero tile then a single nonzero at the last index
        for (int i = 0; i < 32; i++) tile[i] = '0;
        model();
        send_tile(0);
        check_tile("zero");
        hold_release(0, "zero");
        tile[31] = 32'h1234;
        model();
        send_tile(0);
        check("last.map", ia.bit_map, 32'h8000_0000);
        check("last.slot0", ia.nonzero_ele[31:0], 32'h1234);
        check_tile("last");
        hold_release(2, "last");

        // Asynchronous reset after 10 accepts, then a clean tile
        for (int i = 0; i < 10; i++) begin
            ia.in_valid = 1'b1;
            ia.in_data  = 32'h55 + i;
            @(posedge clk); #1;
        end
        ia.in_valid = 1'b0;
        check("prerst.nnz", ia.nnz_count, 10);
        #2 rst = 1'b0;
        #1;
        check_clear("arst");
        #2 rst = 1'b1;
        for (int i = 0; i < 32; i++) tile[i] = (i % 3 == 0) ? rnd_nz() : 32'h0;
        model();
        send_tile(0);
        check_tile("postrst");
        hold_release(1, "postrst");

`ifdef COMPRESS_FLUSH_EN
        // Flush together with the 5th element, value 7 at index 4
        for (int i = 0; i < 32; i++) tile[i] = '0;
        tile[4] = 32'h7;
        model();
        for (int i = 0; i < 5; i++) begin
            ia.in_valid = 1'b1;
            ia.in_data  = tile[i];
            ia.in_flush = (i == 4);
            @(posedge clk); #1;
        end
        ia.in_valid = 1'b0;
        ia.in_flush = 1'b0;
        check("flush.map", ia.bit_map, 32'h0000_0010);
        check("flush.nnz", ia.nnz_count, 1);
        check("flush.slot0", ia.nonzero_ele[31:0], 32'h7);
        check_tile("flush");
        hold_release(1, "flush");
        // Flush with no element at index 0 gives an empty tile
        tile[4] = '0;
        model();
        ia.in_flush = 1'b1;
        @(posedge clk); #1;
        ia.in_flush = 1'b0;
        check_tile("eflush");
        hold_release(0, "eflush");
`endif

        // Randomized tiles of varying density, bubbles and stall lengths
        for (int t = 0; t < 25; t++) begin
            p = $urandom_range(100);
            for (int i = 0; i < 32; i++) tile[i] = ($urandom_range(99) < p) ? rnd_nz() : 32'h0;
            model();
            send_tile(2);
            check_tile($sformatf("rnd%0d", t));
            hold_release($urandom_range(3), $sformatf("rnd%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/bitmap_compressor.md
Name: bitmap_compressor

Overview:
- Sparse-format encoder: the writer side of the bitmap + packed-nonzero tile format consumed by ctr_gen.
- Accepts a dense tile, one element per cycle in row-major order.
- Builds the ROW_SIZE x COL_SIZE occupancy bitmap and packs the nonzero values into a BUFF_SIZE-deep buffer.
- Presents the compressed tile through a valid/ready handshake to the tile loader feeding ctr_gen.

Parameters:
ROW_SIZE, 4, tile rows
COL_SIZE, 8, tile columns
BUFF_SIZE, 32, nonzero buffer depth (slots)
DATA_TYPE, 32, element width in bits
LOG2_ROW_SIZE, 2, log2(ROW_SIZE)
LOG2_COL_SIZE, 3, log2(COL_SIZE)
LOG2_BUFF_SIZE, 5, log2(BUFF_SIZE)

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  dense element valid
in_ready  out  1  block can accept element
in_data  in  DATA_TYPE  dense element value
out_valid  out  1  compressed tile available
out_ready  in  1  downstream takes tile
bit_map  out  ROW_SIZE*COL_SIZE  occupancy; bit r*COL_SIZE+c = element (r,c) nonzero
nonzero_ele  out  BUFF_SIZE*DATA_TYPE  slot k at [k*DATA_TYPE +: DATA_TYPE]
nnz_count  out  LOG2_BUFF_SIZE+1  number of valid slots
overflow  out  1  tile had more nonzeros than BUFF_SIZE

Behaviour:
- Reset (rst low, async): state=COLLECT; element index=0; in_ready=1; out_valid=0; bit_map=0; nonzero_ele=0; nnz_count=0; overflow=0. A reset mid-tile discards the partial tile.
- Element accept = in_valid && in_ready.
- Order: index 0..ROW_SIZE*COL_SIZE-1, row 0 first, column 0 first within a row; row/col derived from the index.
- COLLECT state, in_ready=1. On accept:
  - in_data != 0: set bit_map[index]. If nnz_count < BUFF_SIZE, write slot nnz_count and increment nnz_count. Otherwise drop the value, set overflow (sticky for the tile), leave nnz_count at BUFF_SIZE.
  - in_data == 0: bit stays 0; no slot written.
  - Index increments on every accept. Accepting index ROW_SIZE*COL_SIZE-1 moves to HOLD.
- No accept (in_valid=0): all state holds; bubbles are allowed anywhere.
- HOLD state: in_ready=0, out_valid=1. bit_map, nonzero_ele, nnz_count and overflow are stable.
  - out_valid rises the cycle after the last accept. Latency from last element to out_valid = 1 cycle.
  - On out_valid && out_ready: next cycle clears bit_map, nonzero_ele, nnz_count, overflow and index, sets out_valid=0, and returns to COLLECT with in_ready=1. There is no same-cycle accept of the next tile's first element.
  - out_ready held low keeps HOLD indefinitely. out_ready in COLLECT is ignored.
- Unused slots (k >= nnz_count) read 0.
- Zero test compares the full DATA_TYPE bits against 0; no sign handling.

Optional Feature:
COMPRESS_FLUSH_EN.
- Defined: adds input port in_flush (1 bit). In COLLECT, in_flush=1 ends the tile early and the block goes to HOLD next cycle.
  - in_valid=1 in the same cycle: that element is accepted and encoded first.
  - Unreceived positions remain 0 in bit_map.
  - in_flush is ignored in HOLD.
  - in_flush at index 0 with no element gives an empty tile (out_valid=1, nnz_count=0).
- Undefined: no in_flush port; a tile ends only after ROW_SIZE*COL_SIZE accepts.

Test Plan:
- Reset then 32 back-to-back elements; nonzeros (values 1..11 in order) at row0 cols 2,3,5,6, row2 cols 2,5,7, row3 cols 2,3,5,7 -> cycle after last accept: out_valid=1, bit_map=32'hACA4006C, nnz_count=11, slots 0..10 = 1..11, slot 11+ = 0, overflow=0.
- Same tile with in_valid toggling every other cycle and out_ready held low 5 cycles -> identical outputs, stable through HOLD, in_ready=0 throughout HOLD, tile released on first out_ready.
- All 32 elements = 32'hFFFF_0001 -> bit_map=32'hFFFFFFFF, nnz_count=32, overflow=0. Rerun with BUFF_SIZE=16 -> nnz_count=16, overflow=1, slots 0..15 filled.
- All-zero tile -> bit_map=0, nnz_count=0. Then a second tile with a single nonzero 32'h1234 at index 31 -> bit_map=32'h80000000, slot0=32'h1234.
- rst pulsed low asynchronously after 10 accepts -> outputs zero immediately. The next 32 accepts form a clean tile with no residue.
- COMPRESS_FLUSH_EN: in_flush with the 5th element (value 7 at index 4) -> bit_map=32'h00000010, nnz_count=1, slot0=7.
